regfile_2r1w_sb: RTL
====================

Name: regfile_2r1w_sb

Overview:
Parametrised successor to the team's 8x8 register file. Provides:
- Two independent registered read ports and one write port.
- Write-to-read bypass, so same-cycle writes are visible.
- A per-register busy scoreboard for pending results.

It sits between the decode stage (reads operands, reserves the destination) and the writeback stage (writes results, releases the reservation).

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 3, address width in bits
NUM_REGS, 8, number of implemented registers (1 to 2**ADDR_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_en_a  input  1  port A read strobe
rd_addr_a  input  ADDR_W  port A read address
rd_data_a  output  DATA_W  port A read data (registered)
rd_busy_a  output  1  busy bit of the register read on port A (registered)
rd_en_b  input  1  port B read strobe
rd_addr_b  input  ADDR_W  port B read address
rd_data_b  output  DATA_W  port B read data (registered)
rd_busy_b  output  1  busy bit of the register read on port B (registered)
wr_en  input  1  write strobe; also releases the reservation
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rsv_en  input  1  reserve strobe; marks the destination busy
rsv_addr  input  ADDR_W  register to reserve
busy_vec  output  NUM_REGS  current scoreboard; bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, including mid-operation):
  - All registers = 0.
  - rd_data_a/b = 0, rd_busy_a/b = 0, busy_vec = 0.
  - Strobes are ignored while rst_n is low.
- Write: on clk rise with wr_en=1 and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data. Out-of-range wr_addr is ignored entirely (no data change, no busy change).
- Read latency is 1 cycle. On clk rise with rd_en_x=1:
  - rd_data_x <= effective value of reg[rd_addr_x].
  - rd_busy_x <= next busy bit of rd_addr_x.
- With rd_en_x=0, rd_data_x and rd_busy_x hold their previous values.
- Bypass: if wr_en=1 and wr_addr == rd_addr_x in the same cycle, the effective value is wr_data (new data, not old).
- Out-of-range read address returns data 0 and busy 0.
- Both ports may read the same address in the same cycle; both see identical results.
- Scoreboard, per register i, next-state rule:
  - set = rsv_en && rsv_addr==i.
  - clr = wr_en && wr_addr==i.
  - busy_next[i] = set | (busy[i] & ~clr).
  - Reserve and write to the same address in one cycle leaves the bit set (the new reservation wins).
- Reserving an already-busy register keeps it busy (no count, no error).
- Writing a non-busy register is legal; its busy bit stays 0.
- busy_vec is the registered scoreboard (it reflects busy, not busy_next). rd_busy_x samples busy_next, so it is coherent with the bypassed data.
- No combinational path from any input to any output.

Optional Feature:
Macro REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0: writes to address 0 are dropped and reads of address 0 return 0, with no bypass.
  - rsv_en to address 0 is ignored, so busy_vec[0] is constant 0 and rd_busy for address 0 is 0.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset then read: hold rst_n=0, release, rd_en_a=1 addr 5 -> next cycle rd_data_a=0x00, rd_busy_a=0, busy_vec=0.
- Write then read: wr 0xA5 to r3; next cycle rd_en_a/b addr 3 -> one cycle later rd_data_a = rd_data_b = 0xA5.
- Bypass: wr_en addr 6 data 0x3C and rd_en_a addr 6 in the same cycle -> next cycle rd_data_a=0x3C. With rd_en_a=0 the following cycle, rd_data_a holds 0x3C.
- Scoreboard: rsv r2 -> busy_vec=0x04. Read r2 -> rd_busy_a=1. Write r2 0x11 with rsv r2 in the same cycle -> busy_vec stays 0x04. Write r2 alone -> busy_vec=0x00.
- Async reset mid-operation: after r1=0xFF and r4 busy, pulse rst_n low between clock edges -> outputs and busy_vec go to 0 without a clock edge; a subsequent read of r1 returns 0x00.
- With REGFILE_R0_ZERO_EN: wr r0 0x77 and rsv r0, then read r0 -> rd_data=0x00, busy_vec[0]=0. Without the macro -> rd_data=0x77, busy_vec[0]=1.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read/1-write register file with write bypass and busy scoreboard
// Optional: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero and never reserve it.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic                rd_busy_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                rd_busy_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_ok;
    logic                rsv_ok;
    logic [DATA_W-1:0]   eff_a;
    logic [DATA_W-1:0]   eff_b;
    logic                nb_a;
    logic                nb_b;

    // Out-of-range strobes are dropped here so nothing downstream sees them.
    always_comb begin
        wr_ok  = wr_en  && ({1'b0, wr_addr}  < NREGS);
        rsv_ok = rsv_en && ({1'b0, rsv_addr} < NREGS);
`ifdef REGFILE_R0_ZERO_EN
        if (wr_addr == '0) begin
            wr_ok = 1'b0;
        end
        if (rsv_addr == '0) begin
            rsv_ok = 1'b0;
        end
`endif
    end

    // A reservation in the same cycle as the releasing write wins.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (rsv_ok && (rsv_addr == ADDR_W'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
    end

    always_comb begin
        eff_a = '0;
        eff_b = '0;
        nb_a  = 1'b0;
        nb_b  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                eff_a = regs[i];
                nb_a  = busy_next[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                eff_b = regs[i];
                nb_b  = busy_next[i];
            end
        end
        if (wr_ok && (wr_addr == rd_addr_a)) begin
            eff_a = wr_data;
        end
        if (wr_ok && (wr_addr == rd_addr_b)) begin
            eff_b = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            rd_data_a <= '0;
            rd_busy_a <= 1'b0;
            rd_data_b <= '0;
            rd_busy_b <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
            busy <= busy_next;
            if (rd_en_a) begin
                rd_data_a <= eff_a;
                rd_busy_a <= nb_a;
            end
            if (rd_en_b) begin
                rd_data_b <= eff_b;
                rd_busy_b <= nb_b;
            end
        end
    end

    assign busy_vec = busy;

endmodule
